or4_unit: RTL and testbench
===========================

Name: or4_unit

Overview:
- Registered 4-input OR.
- Computes the bitwise OR of four WIDTH-bit operands and presents it on a clocked output with a valid flag.
- Also provides a reduction "any bit set" flag and a saturating count of non-zero results.
- Used as a datapath primitive wherever a registered OR-combine of four sources is needed; WIDTH=1 is the classic 4-input OR gate.

Parameters:
- WIDTH, 1, bit width of each operand and of o_f.
- CNT_W, 8, width of the non-zero result counter o_hit_cnt.

Ports:
- i_clk  input  1  rising-edge clock.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_en  input  1  sample enable; operands are captured when high.
- i_clr  input  1  synchronous clear of o_hit_cnt.
- i_a  input  WIDTH  operand a.
- i_b  input  WIDTH  operand b.
- i_c  input  WIDTH  operand c.
- i_d  input  WIDTH  operand d.
- o_f  output  WIDTH  registered result, i_a | i_b | i_c | i_d.
- o_valid  output  1  high for the cycle after an enabled sample.
- o_any  output  1  reduction OR of o_f; combinational from the o_f register.
- o_hit_cnt  output  CNT_W  saturating count of enabled samples whose result was non-zero.

Behaviour:
- Interface: one clock (i_clk); reset is asynchronous and active-low (i_rst_n).
- Reset (i_rst_n=0, asynchronous): o_f=0, o_valid=0, o_hit_cnt=0, so o_any=0.
  - Reset mid-operation discards any in-flight result immediately.
  - First capture occurs on the first rising edge after i_rst_n deasserts.
- On a rising edge with i_en=1:
  - o_f <= i_a | i_b | i_c | i_d, bitwise per bit.
  - o_valid <= 1.
  - Latency is exactly 1 cycle from operand sample to o_f.
- On a rising edge with i_en=0:
  - o_f holds its previous value.
  - o_valid <= 0.
- Truth per bit k: o_f[k]=0 only when i_a[k]=i_b[k]=i_c[k]=i_d[k]=0; otherwise 1.
- o_any = |o_f; no additional register stage.
- Hit counter:
  - On an edge with i_en=1 and a non-zero new result, o_hit_cnt increments by 1.
  - It saturates at 2^CNT_W-1 and never wraps.
- i_clr:
  - i_clr=1 on an edge sets o_hit_cnt to 0.
  - i_clr has priority over a simultaneous increment, so the count is 0, not 1.
  - i_clr does not affect o_f or o_valid.
- X/unknown operands are not required to be handled; operands are assumed driven whenever i_en=1.
- No combinational path from any input to any output, except o_any from the o_f register.

Test Plan:
1. Reset/defaults: hold i_rst_n=0 with i_a..i_d=1 and i_en=1 -> o_f=0, o_valid=0, o_any=0, o_hit_cnt=0. Release reset, then one edge later -> o_f=1, o_valid=1.
2. Exhaustive truth table, WIDTH=1: apply all 16 combinations of {a,b,c,d} from 0000 to 1111, one per cycle, with i_en=1.
   - o_f is 0 only for 0000 and 1 for the other 15 combinations, each one cycle after its operands.
   - o_hit_cnt ends at 15.
3. Enable hold: capture a=1 (o_f=1), then drive all operands to 0 with i_en=0 for 3 cycles -> o_f stays 1, o_valid=0. Assert i_en=1 -> o_f=0 next cycle.
4. Multi-bit, WIDTH=4: i_a=4'b0001, i_b=4'b0010, i_c=4'b0000, i_d=4'b1000 -> o_f=4'b1011, o_any=1. All operands 0 -> o_f=0, o_any=0.
5. Counter saturation/clear, CNT_W=2: 5 non-zero samples -> o_hit_cnt=3 (no wrap). Assert i_clr together with a non-zero sample -> o_hit_cnt=0.
6. Async reset mid-stream: pulse i_rst_n low between clock edges while o_f=1 -> o_f, o_valid and o_hit_cnt go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/or4_unit.sv
`default_nettype none
// ============================================================================
//  Module      : or4_unit
//  Description : Registered 4-input bitwise OR with a valid flag, a
//                reduction "any bit set" flag and a saturating count of
//                enabled samples that produced a non-zero result.
//
//  Parameters
//    WIDTH     : bit width of each operand and of o_f
//    CNT_W     : width of the non-zero result counter o_hit_cnt
//
//  Ports
//    i_clk     : rising-edge clock
//    i_rst_n   : asynchronous active-low reset
//    i_en      : sample enable; operands captured when high
//    i_clr     : synchronous clear of o_hit_cnt (wins over an increment)
//    i_a..i_d  : WIDTH-bit operands
//    o_f       : registered i_a | i_b | i_c | i_d
//    o_valid   : high for the cycle after an enabled sample
//    o_any     : reduction OR of the o_f register (no extra stage)
//    o_hit_cnt : saturating count of enabled non-zero results
//
//  Revision    : 1.0  initial release
// ============================================================================
module or4_unit #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_f,
    output logic             o_valid,
    output logic             o_any,
    output logic [CNT_W-1:0] o_hit_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] w_or;
    logic             w_hit;
    logic             w_cnt_sat;

    logic [WIDTH-1:0] r_f;
    logic             r_valid;
    logic [CNT_W-1:0] r_hit_cnt;

    // Per-bit 4-input OR of the incoming operands.
    genvar k;
    generate
        for (k = 0; k < WIDTH; k++) begin : g_bit
            assign w_or[k] = i_a[k] | i_b[k] | i_c[k] | i_d[k];
        end
    endgenerate

    // A hit is judged on the value about to be captured, so the counter
    // and o_f stay consistent on the same edge.
    assign w_hit     = i_en & (|w_or);
    assign w_cnt_sat = (r_hit_cnt == c_CNT_MAX);

    // Result and valid registers; o_f holds when not enabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_f     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_en;
            if (i_en) begin
                r_f <= w_or;
            end
        end
    end

    // Hit counter: clear has priority, then saturating increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hit_cnt <= '0;
        end else if (i_clr) begin
            r_hit_cnt <= '0;
        end else if (w_hit && !w_cnt_sat) begin
            r_hit_cnt <= r_hit_cnt + c_CNT_ONE;
        end
    end

    assign o_f       = r_f;
    assign o_valid   = r_valid;
    assign o_any     = |r_f;
    assign o_hit_cnt = r_hit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_or4_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_or4_unit
//  Description : Self-checking bench for or4_unit. Two instances share the
//                operand buses: a WIDTH=1/CNT_W=8 gate and a WIDTH=4/CNT_W=2
//                datapath copy. A behavioural model tracks both.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_or4_unit;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [3:0] a, b, c, d;

    logic       f1;
    logic       valid1;
    logic       any1;
    logic [7:0] cnt1;

    logic [3:0] f4;
    logic       valid4;
    logic       any4;
    logic [1:0] cnt4;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_f1, m_f4, m_valid, m_cnt1, m_cnt4;

    or4_unit #(.WIDTH(1), .CNT_W(8)) u_w1 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_en      (en),
        .i_clr     (clr),
        .i_a       (a[0:0]),
        .i_b       (b[0:0]),
        .i_c       (c[0:0]),
        .i_d       (d[0:0]),
        .o_f       (f1),
        .o_valid   (valid1),
        .o_any     (any1),
        .o_hit_cnt (cnt1)
    );

    or4_unit #(.WIDTH(4), .CNT_W(2)) u_w4 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_en      (en),
        .i_clr     (clr),
        .i_a       (a),
        .i_b       (b),
        .i_c       (c),
        .i_d       (d),
        .o_f       (f4),
        .o_valid   (valid4),
        .o_any     (any4),
        .o_hit_cnt (cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_f1 = 0; m_f4 = 0; m_valid = 0; m_cnt1 = 0; m_cnt4 = 0;
    endtask

    // Model of one rising edge from the currently applied inputs.
    task automatic model_edge();
        int res;
        int ones;
        res = 0;
        for (int k = 0; k < 4; k++) begin
            ones = int'(a[k]) + int'(b[k]) + int'(c[k]) + int'(d[k]);
            if (ones > 0) res += (1 << k);
        end
        if (en) begin
            m_f4 = res;
            m_f1 = res % 2;
            m_valid = 1;
            if (m_f1 != 0) m_cnt1 = (m_cnt1 + 1 > 255) ? 255 : m_cnt1 + 1;
            if (m_f4 != 0) m_cnt4 = (m_cnt4 + 1 > 3) ? 3 : m_cnt4 + 1;
        end else begin
            m_valid = 0;
        end
        if (clr) begin
            m_cnt1 = 0;
            m_cnt4 = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".f1"},     32'(f1),     32'(m_f1));
        check({tag, ".valid1"}, 32'(valid1), 32'(m_valid));
        check({tag, ".any1"},   32'(any1),   32'(m_f1 != 0));
        check({tag, ".cnt1"},   32'(cnt1),   32'(m_cnt1));
        check({tag, ".f4"},     32'(f4),     32'(m_f4));
        check({tag, ".valid4"}, 32'(valid4), 32'(m_valid));
        check({tag, ".any4"},   32'(any4),   32'(m_f4 != 0));
        check({tag, ".cnt4"},   32'(cnt4),   32'(m_cnt4));
    endtask

    task automatic drive(input logic e, input logic cl,
                         input logic [3:0] va, input logic [3:0] vb,
                         input logic [3:0] vc, input logic [3:0] vd);
        @(negedge clk);
        en = e; clr = cl; a = va; b = vb; c = vc; d = vd;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    function automatic logic [3:0] rnd_op();
        if ($urandom_range(1, 0) == 0) return 4'h0;
        return 4'($urandom_range(15, 0));
    endfunction

    initial begin
        // 1. Reset with operands and enable active
        rst_n = 1'b0; en = 1'b1; clr = 1'b0;
        a = 4'h1; b = 4'h1; c = 4'h1; d = 4'h1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick("first_capture");
        check("first_f1", 32'(f1), 32'd1);

        // 2. Exhaustive truth table on the 1-bit instance from a cleared count
        drive(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
        tick("clr_before_tt");
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            drive(1'b1, 1'b0, {3'b0, v[3]}, {3'b0, v[2]}, {3'b0, v[1]}, {3'b0, v[0]});
            tick("truth");
        end
        check("tt_cnt1", 32'(cnt1), 32'd15);

        // 3. Enable hold
        drive(1'b1, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0);
        tick("hold_cap");
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
            tick("hold");
            check("hold_f1", 32'(f1), 32'd1);
        end
        drive(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        tick("hold_release");
        check("hold_release_f1", 32'(f1), 32'd0);

        // 4. Multi-bit OR
        drive(1'b1, 1'b0, 4'b0001, 4'b0010, 4'b0000, 4'b1000);
        tick("multibit");
        check("multibit_f4", 32'(f4), 32'hB);
        check("multibit_any4", 32'(any4), 32'd1);
        drive(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        tick("multibit_zero");
        check("zero_any4", 32'(any4), 32'd0);

        // 5. Saturation and clear priority on the 2-bit counter
        drive(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
        tick("sat_clr");
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 4'h3, 4'h0, 4'h0, 4'h0);
            tick("sat");
        end
        check("sat_cnt4", 32'(cnt4), 32'd3);
        drive(1'b1, 1'b1, 4'h5, 4'h0, 4'h0, 4'h0);
        tick("clr_prio");
        check("clr_prio_cnt4", 32'(cnt4), 32'd0);
        check("clr_prio_cnt1", 32'(cnt1), 32'd0);
        check("clr_prio_valid4", 32'(valid4), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(3, 0) != 0), 1'($urandom_range(15, 0) == 0),
                  rnd_op(), rnd_op(), rnd_op(), rnd_op());
            tick("rand");
        end

        // 6. Asynchronous reset between edges
        drive(1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0);
        tick("pre_async");
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        compare_all("async_rst");
        check("async_f4", 32'(f4), 32'd0);
        #1 rst_n = 1'b1;
        tick("post_async");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
